// File: rtl/data_mem_responder.sv
// data_mem_responder
//   MEM-stage data memory responder. Accepts one load/store request at a
//   time, answers it LATENCY cycles after acceptance with a one-cycle
//   resp_valid strobe, and asks the pipeline to freeze while a request is
//   outstanding.
//
//   State table:
//     IDLE | no request outstanding, ready to accept
//     WAIT | request latched, counting down to the response cycle
//     RESP | response cycle (resp_valid=1), may accept the next request
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   req_valid    request present
//   req_write    1 = store, 0 = load
//   req_addr     byte address; word index = req_addr[15:1]
//   req_wdata    store data
//   req_ready    a request can be accepted this cycle
//   resp_valid   one-cycle response strobe
//   resp_rdata   load data (0 for stores and errors), held between responses
//   resp_err     misaligned or out-of-range access, held between responses
//   mem_stall    pipeline freeze request
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_stall
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = 3;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt, next_cnt;
    logic            accept;
    logic            commit;

    logic            lat_write;
    logic [15:0]     lat_addr;
    logic [15:0]     lat_wdata;

    logic            c_write;
    logic [15:0]     c_addr;
    logic [15:0]     c_wdata;
    logic [31:0]     c_word;
    logic            c_err;
    logic [AW-1:0]   c_idx;

    logic [15:0]     mem [DEPTH_WORDS];

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        req_ready  = 1'b0;
        accept     = 1'b0;
        mem_stall  = 1'b0;
        if (!reset) begin
            req_ready = (state != WAIT);
            accept    = req_valid & req_ready;
            mem_stall = accept | (state == WAIT);
        end
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = CNT_LOAD;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);

    // With LATENCY=1 the commit edge is also the accept edge, so the live
    // request inputs are used instead of the (not yet loaded) latch.
    assign c_write = accept ? req_write : lat_write;
    assign c_addr  = accept ? req_addr  : lat_addr;
    assign c_wdata = accept ? req_wdata : lat_wdata;
    assign c_word  = {17'd0, c_addr[15:1]};
    assign c_err   = c_addr[0] | (c_word >= 32'(DEPTH_WORDS));
    assign c_idx   = c_addr[AW:1];
    assign commit  = !reset && (next_state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (commit) begin
                resp_err   <= c_err;
                resp_rdata <= (c_write || c_err) ? 16'd0 : mem[c_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (commit && c_write && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three lanes with LATENCY 1, 2 and 3, each
// checked every cycle against a transaction-level model (pending request
// with a due cycle, plain array memory), plus directed scenarios with
// literal expectations.
module tb_data_mem_responder;

    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        rv    [3];
    logic        rw    [3];
    logic [15:0] ra    [3];
    logic [15:0] rd    [3];
    logic        rdy   [3];
    logic        vld   [3];
    logic [15:0] rdat  [3];
    logic        err   [3];
    logic        stall [3];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(g + 1)) dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req_valid (rv[g]),
            .req_write (rw[g]),
            .req_addr  (ra[g]),
            .req_wdata (rd[g]),
            .req_ready (rdy[g]),
            .resp_valid(vld[g]),
            .resp_rdata(rdat[g]),
            .resp_err  (err[g]),
            .mem_stall (stall[g])
        );

        logic [15:0] m_mem [DEPTH] = '{default: 16'd0};
        bit          pend    = 1'b0;
        int          due     = 0;
        int          cyc     = 0;
        bit          p_w     = 1'b0;
        logic [15:0] p_a     = '0;
        logic [15:0] p_d     = '0;
        logic [15:0] h_rdata = '0;
        bit          h_err   = 1'b0;
        bit          in_wait, in_resp, e_ready, e_acc, bad;

        always @(negedge clk) begin
            in_resp = pend && (cyc == due);
            in_wait = pend && (cyc < due);
            e_ready = !rst[g] && !in_wait;
            e_acc   = rv[g] && e_ready;
            check($sformatf("L%0d ready", g + 1), rdy[g], e_ready);
            check($sformatf("L%0d stall", g + 1), stall[g], !rst[g] && (e_acc || in_wait));
            check($sformatf("L%0d valid", g + 1), vld[g], in_resp);
            check($sformatf("L%0d rdata", g + 1), rdat[g], h_rdata);
            check($sformatf("L%0d err", g + 1), err[g], h_err);
            if (rst[g]) begin
                pend    = 1'b0;
                h_rdata = '0;
                h_err   = 1'b0;
                m_mem   = '{default: 16'd0};
            end else begin
                if (e_acc) begin
                    pend = 1'b1;
                    due  = cyc + g + 1;
                    p_w  = rw[g];
                    p_a  = ra[g];
                    p_d  = rd[g];
                end else if (in_resp) begin
                    pend = 1'b0;
                end
                if (pend && due == cyc + 1) begin
                    bad     = p_a[0] || (int'(p_a[15:1]) >= DEPTH);
                    h_err   = bad;
                    h_rdata = (bad || p_w) ? 16'd0 : m_mem[p_a[7:1]];
                    if (p_w && !bad) m_mem[p_a[7:1]] = p_d;
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        rv[k] = v; rw[k] = w; ra[k] = a; rd[k] = d;
    endtask

    task automatic txn(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] q, output logic e, output int lat);
        bit got = 1'b0;
        lat = -1;
        q   = '0;
        e   = 1'b0;
        set_req(k, 1'b1, w, a, d);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (rdy[k]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        step();
        rv[k] = 1'b0;
        if (!got) check("txn accept timeout", 32'd0, 32'd1);
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (vld[k]) begin
                lat = t;
                q   = rdat[k];
                e   = err[k];
                break;
            end
            step();
        end
        step();
    endtask

    logic [15:0] q;
    logic        e;
    int          lat;

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            set_req(k, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        // Reset held with a pending load on lane 0 (LATENCY=1).
        set_req(0, 1'b1, 1'b0, 16'h0006, 16'h0);
        repeat (3) begin
            @(negedge clk);
            check("rst ready", rdy[0], 1'b0);
            check("rst stall", stall[0], 1'b0);
            check("rst valid", vld[0], 1'b0);
            step();
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        check("post-rst accept ready", rdy[0], 1'b1);
        check("post-rst accept stall", stall[0], 1'b1);
        step();
        rv[0] = 1'b0;
        @(negedge clk);
        check("post-rst resp valid", vld[0], 1'b1);
        check("post-rst resp rdata", rdat[0], 16'h0000);
        step();

        // LATENCY=1: store then immediately load the same word.
        set_req(0, 1'b1, 1'b1, 16'h0002, 16'h00AA);
        @(negedge clk);
        check("L1 store accept", rdy[0], 1'b1);
        step();
        set_req(0, 1'b1, 1'b0, 16'h0002, 16'h0);
        @(negedge clk);
        check("L1 store resp valid", vld[0], 1'b1);
        check("L1 store resp rdata", rdat[0], 16'h0000);
        check("L1 b2b accept stall", stall[0], 1'b1);
        step();
        rv[0] = 1'b0;
        @(negedge clk);
        check("L1 load resp valid", vld[0], 1'b1);
        check("L1 load rdata", rdat[0], 16'h00AA);
        check("L1 load err", err[0], 1'b0);
        step();

        // LATENCY=2: store 0xBEEF to 0x0010 with cycle-exact stall timing.
        set_req(1, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        @(negedge clk);
        check("L2 stall N", stall[1], 1'b1);
        step();
        rv[1] = 1'b0;
        @(negedge clk);
        check("L2 stall N+1", stall[1], 1'b1);
        check("L2 ready N+1", rdy[1], 1'b0);
        step();
        @(negedge clk);
        check("L2 resp valid N+2", vld[1], 1'b1);
        check("L2 store err", err[1], 1'b0);
        check("L2 store rdata", rdat[1], 16'h0000);
        check("L2 stall N+2", stall[1], 1'b0);
        step();
        txn(1, 1'b0, 16'h0010, 16'h0, q, e, lat);
        check("L2 load BEEF", q, 16'hBEEF);
        check("L2 load latency", lat, 2);

        // Error cases.
        txn(1, 1'b0, 16'h0011, 16'h0, q, e, lat);
        check("misaligned err", e, 1'b1);
        check("misaligned rdata", q, 16'h0000);
        txn(1, 1'b1, 16'h0100, 16'h1234, q, e, lat);
        check("out-of-range err", e, 1'b1);
        txn(1, 1'b0, 16'h0000, 16'h0, q, e, lat);
        check("word0 unaffected", q, 16'h0000);
        check("word0 err", e, 1'b0);

        // Reset during WAIT drops the outstanding store.
        set_req(1, 1'b1, 1'b1, 16'h0004, 16'h5555);
        @(negedge clk);
        check("drop accept", rdy[1], 1'b1);
        step();
        rv[1]  = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        check("drop stall in rst", stall[1], 1'b0);
        step();
        rst[1] = 1'b0;
        @(negedge clk);
        check("drop no valid", vld[1], 1'b0);
        step();
        step();
        txn(1, 1'b0, 16'h0004, 16'h0, q, e, lat);
        check("dropped store", q, 16'h0000);

        // LATENCY=3: held req_valid, back-to-back accept in the RESP cycle.
        set_req(2, 1'b1, 1'b0, 16'h0020, 16'h0);
        @(negedge clk);
        check("L3 accept N", rdy[2], 1'b1);
        step();
        @(negedge clk);
        check("L3 ready N+1", rdy[2], 1'b0);
        step();
        @(negedge clk);
        check("L3 ready N+2", rdy[2], 1'b0);
        step();
        @(negedge clk);
        check("L3 valid N+3", vld[2], 1'b1);
        check("L3 ready N+3", rdy[2], 1'b1);
        check("L3 stall N+3", stall[2], 1'b1);
        step();
        rv[2] = 1'b0;
        @(negedge clk);
        check("L3 valid N+4", vld[2], 1'b0);
        step();
        @(negedge clk);
        check("L3 valid N+5", vld[2], 1'b0);
        step();
        @(negedge clk);
        check("L3 valid N+6", vld[2], 1'b1);
        step();

        // Randomized traffic on all lanes.
        repeat (3000) begin
            for (int k = 0; k < 3; k++) begin
                int wi;
                int odd;
                wi  = ($urandom_range(0, 15) == 0) ? 32767 : int'($urandom_range(0, 135));
                odd = ($urandom_range(0, 7) == 0) ? 1 : 0;
                rst[k] = ($urandom_range(0, 59) == 0);
                set_req(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        16'(wi * 2 + odd), 16'($urandom));
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0;
            rv[k]  = 1'b0;
        end
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
